// File: rtl/serial_mult_ctrl_if.sv
// Handshake and operand/result bundle for the bit-serial multiplier.
// The host drives start/A/B through the master modport; the multiplier
// returns the product and the busy/done status through the slave modport.
interface serial_mult_ctrl_if #(
  parameter int N = 3
);
  logic           start;
  logic [N-1:0]   A;
  logic [N-1:0]   B;
  logic [2*N-1:0] P;
  logic           busy;
  logic           done;

  modport master (output start, A, B, input P, busy, done);
  modport slave  (input start, A, B, output P, busy, done);
endinterface

// File: rtl/serial_mult_ctrl.sv
// Bit-serial shift-and-add unsigned multiplier.
// A single full adder is time-shared: each iteration ripples the (gated)
// multiplicand into the HI accumulator one bit per cycle, then one shift
// cycle moves the finished low bit into LO. An N x N product therefore takes
// N*(N+1) busy cycles, followed by a one-cycle done pulse.

module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);
  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);
endmodule

module serial_mult_ctrl #(
  parameter int N = 3
) (
  input logic               clk,
  input logic               rst,
  serial_mult_ctrl_if.slave bus
);

  localparam int KW = $clog2(N);
  localparam logic [KW-1:0] K_LAST = KW'(N - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ADD   = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t        state_q;
  state_t        state_d;
  logic [N-1:0]  m_q;
  logic [N-1:0]  hi_q;
  logic [N-1:0]  lo_q;
  logic          c_q;
  logic [KW-1:0] k_q;
  logic [KW-1:0] it_q;

  logic fa_a;
  logic fa_b;
  logic fa_s;
  logic fa_cout;

  // The only adder in the block: bit k of the accumulator plus bit k of the
  // multiplicand, gated by the current multiplier bit, plus the running carry.
  assign fa_a = hi_q[k_q];
  assign fa_b = m_q[k_q] & lo_q[0];

  full_adder u_fa (
    .a    (fa_a),
    .b    (fa_b),
    .cin  (c_q),
    .s    (fa_s),
    .cout (fa_cout)
  );

  // State register; async reset returns to IDLE from anywhere.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state decode; start only matters in IDLE and is never queued.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = ADD;
      ADD:     if (k_q == K_LAST) state_d = SHIFT;
      SHIFT:   state_d = (it_q == K_LAST) ? DONE : ADD;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath: operand load, serial add, shift; everything clears on reset so
  // no partial product survives an aborted operation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_q  <= '0;
      hi_q <= '0;
      lo_q <= '0;
      c_q  <= 1'b0;
      k_q  <= '0;
      it_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            m_q  <= bus.A;
            lo_q <= bus.B;
            hi_q <= '0;
            c_q  <= 1'b0;
            k_q  <= '0;
            it_q <= '0;
          end
        end
        ADD: begin
          hi_q[k_q] <= fa_s;
          c_q       <= fa_cout;
          k_q       <= (k_q == K_LAST) ? '0 : k_q + KW'(1);
        end
        SHIFT: begin
          hi_q <= {c_q, hi_q[N-1:1]};
          lo_q <= {hi_q[0], lo_q[N-1:1]};
          c_q  <= 1'b0;
          if (it_q != K_LAST) it_q <= it_q + KW'(1);
        end
        default: ;
      endcase
    end
  end

  // Status is decoded from state alone so it never follows start combinationally.
  assign bus.P    = {hi_q, lo_q};
  assign bus.busy = (state_q == ADD) || (state_q == SHIFT);
  assign bus.done = (state_q == DONE);

endmodule

// File: tb/tb_serial_mult_ctrl.sv
// Directed bench for serial_mult_ctrl with N=3.
module tb_serial_mult_ctrl;

  localparam int N = 3;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  serial_mult_ctrl_if #(.N(N)) bus ();

  serial_mult_ctrl #(.N(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Issue one multiply at the current negedge and follow it to completion.
  // Returns at the negedge after the DONE cycle (FSM back in IDLE), so a
  // following call issues its start as early as the controller accepts it.
  // With jam set, start is held high with A=B=7 for the whole operation.
  task automatic run_mult(input string tag, input int a, input int b, input bit jam);
    int lat;
    int busy_cnt;
    bus.start = 1'b1;
    bus.A     = N'(a);
    bus.B     = N'(b);
    @(negedge clk);
    if (jam) begin
      bus.A = 3'd7;
      bus.B = 3'd7;
    end else begin
      bus.start = 1'b0;
    end
    lat      = 0;
    busy_cnt = 0;
    while (bus.done !== 1'b1 && lat < 40) begin
      lat++;
      if (bus.busy === 1'b1) busy_cnt++;
      @(negedge clk);
    end
    bus.start = 1'b0;
    check({tag, " latency"}, 32'(lat), 32'd12);
    check({tag, " busy_cycles"}, 32'(busy_cnt), 32'd12);
    check({tag, " P_at_done"}, 32'(bus.P), 32'(a * b));
    check({tag, " busy_at_done"}, 32'(bus.busy), 32'd0);
    @(negedge clk);
    check({tag, " done_one_cycle"}, 32'(bus.done), 32'd0);
    check({tag, " busy_idle"}, 32'(bus.busy), 32'd0);
    check({tag, " P_held"}, 32'(bus.P), 32'(a * b));
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    rst       = 1'b1;
    bus.start = 1'b1;
    bus.A     = 3'd7;
    bus.B     = 3'd7;

    // Power-up with reset held and start asserted.
    repeat (3) @(negedge clk);
    check("por P", 32'(bus.P), 32'd0);
    check("por busy", 32'(bus.busy), 32'd0);
    check("por done", 32'(bus.done), 32'd0);
    bus.start = 1'b0;
    rst       = 1'b0;
    @(negedge clk);
    check("post_rst busy", 32'(bus.busy), 32'd0);
    check("post_rst P", 32'(bus.P), 32'd0);

    // Basic 3*3, then P must stay put for a few idle cycles.
    run_mult("m3x3", 3, 3, 1'b0);
    repeat (3) @(negedge clk);
    check("m3x3 P_hold_idle", 32'(bus.P), 32'd9);
    check("m3x3 busy_idle2", 32'(bus.busy), 32'd0);

    // Corner operands.
    run_mult("m7x7", 7, 7, 1'b0);
    run_mult("m0x5", 0, 5, 1'b0);
    run_mult("m5x0", 5, 0, 1'b0);
    run_mult("m1x7", 1, 7, 1'b0);

    // All 64 pairs, back to back.
    for (int a = 0; a < 8; a++) begin
      for (int b = 0; b < 8; b++) begin
        run_mult($sformatf("sweep_%0dx%0d", a, b), a, b, 1'b0);
      end
    end

    // Start held high with other operands through ADD/SHIFT/DONE is ignored.
    run_mult("ignore", 2, 3, 1'b1);
    repeat (2) @(negedge clk);
    check("ignore no_restart_busy", 32'(bus.busy), 32'd0);
    check("ignore no_second_done", 32'(bus.done), 32'd0);
    check("ignore P", 32'(bus.P), 32'd6);

    // Asynchronous reset in the middle of 6*5.
    bus.start = 1'b1;
    bus.A     = 3'd6;
    bus.B     = 3'd5;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (4) @(negedge clk);
    check("abort busy_before", 32'(bus.busy), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("abort busy", 32'(bus.busy), 32'd0);
    check("abort P", 32'(bus.P), 32'd0);
    check("abort done", 32'(bus.done), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("abort idle busy", 32'(bus.busy), 32'd0);
    check("abort idle P", 32'(bus.P), 32'd0);
    run_mult("m6x5", 6, 5, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/serial_mult_ctrl.md
# serial_mult_ctrl

Bit-serial shift-and-add unsigned multiplier controller that time-shares one `full_adder` instance to compute an N×N product over multiple cycles. It sits above the `full_adder` primitive in the multiplier datapath. It replaces the combinational 3-bit array multiplier where area matters more than latency. A start/busy/done handshake lets a host sequence one multiplication at a time.

## Interface
- `N`, default 3: operand width in bits; legal range N ≥ 2.
- `clk`  input  1  rising-edge clock.
- `rst`  input  1  asynchronous, active-high reset.
- `start`  input  1  request; sampled only in IDLE.
- `A`  input  N  multiplicand, unsigned; sampled with `start`.
- `B`  input  N  multiplier, unsigned; sampled with `start`.
- `P`  output  2N  product register `{HI, LO}`.
- `busy`  output  1  high in ADD and SHIFT.
- `done`  output  1  one-cycle completion pulse; high in DONE.

## Operation
- Internal registers:
  - `M[N-1:0]`: latched multiplicand.
  - `HI[N-1:0]`: accumulator.
  - `LO[N-1:0]`: multiplier, then low product bits.
  - `C`: carry flop.
  - `k`: bit index, 0..N-1.
  - `it`: iteration count, 0..N-1.
- Exactly one `full_adder` instance. Its inputs are `A = HI[k]`, `B = M[k] & LO[0]`, `Cin = C`. No other adder logic is allowed in the block.
- States: IDLE, ADD, SHIFT, DONE.
- **IDLE**
  - On `start = 1`: load `M <= A`, `LO <= B`, `HI <= 0`, `C <= 0`, `k <= 0`, `it <= 0`, then go to ADD.
  - Otherwise stay in IDLE.
- **ADD**
  - Each cycle: `HI[k] <= S`, `C <= Cout`.
  - If `k == N-1`: set `k <= 0` and go to SHIFT. Otherwise `k <= k+1`.
- **SHIFT**
  - Shift right by one: `HI <= {C, HI[N-1:1]}`, `LO <= {HI[0], LO[N-1:1]}`, `C <= 0`.
  - If `it == N-1`: go to DONE. Otherwise `it <= it+1` and go to ADD.
- **DONE**
  - `done = 1`.
  - Unconditionally go to IDLE.
- `P` is continuously `{HI, LO}`:
  - It is valid from DONE onward.
  - It holds its value through IDLE until the next accepted `start`.
  - It shows intermediate values while `busy` is high.
- `start` is ignored while in ADD, SHIFT or DONE. It is not queued.
- Width rule: `HI` plus `C` never overflows, because the maximum product is (2^N−1)² < 2^(2N).
- Reset (asynchronous, any state including mid-operation):
  - State goes to IDLE.
  - `HI`, `LO`, `M`, `C`, `k`, `it` are cleared to 0.
  - Outputs after reset: `P = 0`, `busy = 0`, `done = 0`.
  - No partial result survives reset.
- `busy` and `done` are decoded from state only; they never depend combinationally on `start`.

## Timing
- `start` is sampled high at edge E in IDLE, so ADD begins after E.
- Each iteration takes N ADD cycles plus 1 SHIFT cycle. Total is N(N+1) cycles; 12 for N=3.
- Final shift commits at edge E+N(N+1). DONE and `done = 1` hold for the cycle following that edge.
- Next IDLE begins at E+N(N+1)+1. The earliest next accepted `start` is sampled at that edge's following cycle, so the issue interval is N(N+1)+2 cycles.
- `busy` is high for exactly N(N+1) cycles: from E to E+N(N+1).
- Reset asserted asynchronously drops `busy` and `done` immediately, without waiting for a clock edge.

## Test plan
- N=3, A=3, B=3, `start` pulse at edge E:
  - `busy` high for 12 cycles, `done` high for exactly one cycle after edge E+12.
  - `P = 6'b001001` (9), held until the next `start`.
- Corner values, each: A=7, B=7 → `P = 49` (`6'b110001`); A=0, B=5 → `P = 0`; A=5, B=0 → `P = 0`; A=1, B=7 → `P = 7`.
- Exhaustive sweep of all 64 (A, B) pairs with back-to-back starts issued as soon as IDLE is reached:
  - Every `P == A*B`.
  - Every `done` pulse appears exactly 12 edges after its `start`.
- Ignored start:
  - Start A=2, B=3, then assert `start` with A=7, B=7 during ADD, SHIFT and DONE.
  - Result is `P = 6`; no second `done` pulse; `busy` not extended.
- Reset mid-operation:
  - Start A=6, B=5, assert `rst` asynchronously at cycle 5 (between edges).
  - `busy = 0` and `P = 0` immediately; after release the FSM is in IDLE.
  - A new start with A=6, B=5 gives `P = 30` after 12 cycles.
- Reset values: on power-up with `rst` held high, `P = 0`, `busy = 0`, `done = 0`, and `start = 1` is ignored until `rst` deasserts.
